midi_out_port: RTL
==================

MIDI_OUT_PORT -- requirements
Module: midi_out_port

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, output byte FIFO depth; power of 2, range 4..16.
REQ-002 SHALL have parameter RUNNING_STATUS, default 1; 1 = omit repeated channel status bytes, 0 = always send status.
REQ-003 SHALL have port reg_clk  in  1  system clock; all logic on posedge.
REQ-004 SHALL have port reset_reg_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port msg_valid  in  1  synth offers a message.
REQ-006 SHALL have port msg_ready  out  1  block accepts the message this cycle.
REQ-007 SHALL have port msg_status  in  8  MIDI status byte.
REQ-008 SHALL have port msg_data1  in  8  first data byte.
REQ-009 SHALL have port msg_data2  in  8  second data byte.
REQ-010 SHALL have port msg_len  in  2  data byte count 0..2; value 3 is treated as 2.
REQ-011 SHALL have port socmidi_addr  in  3  CPU register address.
REQ-012 SHALL have port socmidi_read  in  1  CPU read strobe, single-cycle pulse synchronous to reg_clk.
REQ-013 SHALL have port socmidi_data_out  out  8  registered read data.
REQ-014 SHALL have port midi_irq  out  1  registered; high while FIFO non-empty.

Function
REQ-015 SHALL accept a message on a cycle with msg_valid && msg_ready, capturing all msg_* inputs.
REQ-016 SHALL drive msg_ready high only in FSM state IDLE.
REQ-017 SHALL implement FSM states IDLE, SEND_ST, SEND_D1, SEND_D2.
- Accept with bit7 of msg_status clear: drop message, set sticky bad_msg, stay IDLE.
- Accept, valid status: go to SEND_ST, or to SEND_D1/IDLE when the status byte is skipped (REQ-019).
- Each SEND state: push one byte when FIFO not full; otherwise hold state (stall).
- SEND_ST goes to SEND_D1 if len>=1, else IDLE; SEND_D1 goes to SEND_D2 if len==2, else IDLE; SEND_D2 goes to IDLE.
REQ-018 SHALL force bit7 of every pushed data byte to 0.
REQ-019 SHALL skip the status byte when RUNNING_STATUS=1, msg_status is in 0x80..0xEF, and msg_status equals last_status.
- A skipped status with len 0 pushes nothing and returns to IDLE.
REQ-020 SHALL update last_status as follows:
- set to msg_status on accepting 0x80..0xEF;
- clear to 0x00 on accepting 0xF0..0xF7;
- leave unchanged on accepting 0xF8..0xFF.
REQ-021 SHALL evaluate FIFO full from the registered count; a push is blocked on a full cycle even if a pop occurs in the same cycle.
- A pop and a push in the same non-full cycle SHALL both take effect and leave the count unchanged.
REQ-022 SHALL handle a socmidi_read at addr 0 as follows:
- next cycle, socmidi_data_out = FIFO head and the entry is popped;
- if the FIFO is empty, socmidi_data_out = 0x00 and no pop occurs.
REQ-023 SHALL handle a socmidi_read at addr 1 as follows:
- next cycle, socmidi_data_out = {count[4:0], bad_msg, full, not_empty}, sampled before the read's side effects;
- bad_msg SHALL then be cleared;
- a bad_msg event in the same cycle as the read SHALL win and stay set.
REQ-024 SHALL return 0x00 for a read at any other address; socmidi_data_out SHALL hold its value when no read occurs.
REQ-025 SHALL set midi_irq one cycle after the FIFO count changes (registered not-empty).
REQ-026 SHALL keep count in the range 0..FIFO_DEPTH, with pointers wrapping modulo FIFO_DEPTH.

Reset
REQ-027 SHALL, while reset_reg_N is low, immediately force the following, including mid-message (partial message discarded):
- FSM to IDLE; FIFO emptied with pointers and count 0;
- last_status = 0x00; bad_msg = 0;
- socmidi_data_out = 0x00; midi_irq = 0; msg_ready = 0.
REQ-028 SHALL assert msg_ready on the first clock edge after reset release.

Verification
REQ-029 SHALL cover: after reset, accept 0x90/0x3C/0x64 with len 2 -> FIFO count 3, midi_irq=1; three addr-0 reads return 0x90, 0x3C, 0x64; then midi_irq=0.
REQ-030 SHALL cover: running status, then cancellation.
- 0x90/0x3C/0x64, then 0x90/0x40/0x00 -> 5 bytes, second status omitted.
- Then 0xF8 len 0, then 0x90/0x41/0x10 -> 0xF8 pushed and 0x90 still omitted.
- Then 0xF2 len 2, then 0x90 -> status resent.
REQ-031 SHALL cover: push 16 bytes with no reads -> status read gives full=1, count=16 (0x83); a further message stalls with msg_ready=0; one addr-0 read -> the stalled byte is pushed the following cycle.
REQ-032 SHALL cover: addr-0 read on an empty FIFO -> 0x00 returned, count stays 0, midi_irq stays 0.
REQ-033 SHALL cover: bad status and data masking.
- msg_status 0x40 -> nothing pushed; addr-1 read returns bit2=1; a second addr-1 read returns bit2=0.
- data1 0xFF -> pushed as 0x7F.
REQ-034 SHALL cover: reset_reg_N pulsed low while in SEND_D1 -> FIFO empty, FSM in IDLE, and the next 0x90 message is sent with its status byte.

Source files
------------

// File: rtl/midi_out_port.sv
// midi_out_port: MIDI message serializer into a CPU-readable byte FIFO with running status
module midi_out_port #(
    parameter int FIFO_DEPTH     = 16,
    parameter bit RUNNING_STATUS = 1'b1
) (
    input  logic       reg_clk,
    input  logic       reset_reg_N,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [7:0] msg_data1,
    input  logic [7:0] msg_data2,
    input  logic [1:0] msg_len,
    input  logic [2:0] socmidi_addr,
    input  logic       socmidi_read,
    output logic [7:0] socmidi_data_out,
    output logic       midi_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SEND_ST, SEND_D1, SEND_D2} state_t;

    state_t state_q, state_d;
    logic [7:0] st_q, st_d, d1_q, d1_d, d2_q, d2_d, last_q, last_d, dout_q, dout_d;
    logic [1:0] len_q, len_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [4:0] cnt_q, cnt_d;
    logic bad_q, bad_d, irq_q, irq_d, rdy_q, rdy_d;
    logic [7:0] mem [FIFO_DEPTH];
    logic acc, full, not_empty, push, pop, chan, skip;
    logic [7:0] push_byte;
    logic [1:0] len_in;

    assign msg_ready        = rdy_q && state_q == IDLE;
    assign socmidi_data_out = dout_q;
    assign midi_irq         = irq_q;

    // message sequencing, FIFO bookkeeping and CPU register reads
    always_comb begin
        full      = cnt_q == 5'(FIFO_DEPTH);
        not_empty = cnt_q != 5'd0;
        acc       = msg_valid && msg_ready;
        len_in    = msg_len == 2'd3 ? 2'd2 : msg_len;
        chan      = msg_status >= 8'h80 && msg_status <= 8'hEF;
        skip      = RUNNING_STATUS && chan && msg_status == last_q;
        push      = state_q != IDLE && !full;
        push_byte = state_q == SEND_ST ? st_q : {1'b0, state_q == SEND_D1 ? d1_q[6:0] : d2_q[6:0]};
        pop       = socmidi_read && socmidi_addr == 3'd0 && not_empty;
        state_d   = state_q;
        st_d      = st_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        len_d     = len_q;
        last_d    = last_q;
        if (acc && msg_status[7]) begin
            st_d    = msg_status;
            d1_d    = msg_data1;
            d2_d    = msg_data2;
            len_d   = len_in;
            state_d = !skip ? SEND_ST : len_in != 2'd0 ? SEND_D1 : IDLE;
            last_d  = chan ? msg_status : msg_status < 8'hF8 ? 8'h00 : last_q;
        end
        if (push)
            state_d = state_q == SEND_ST && len_q != 2'd0 ? SEND_D1 :
                      state_q == SEND_D1 && len_q == 2'd2 ? SEND_D2 : IDLE;
        wr_d   = push ? wr_q + AW'(1) : wr_q;
        rd_d   = pop ? rd_q + AW'(1) : rd_q;
        cnt_d  = cnt_q + 5'(push) - 5'(pop);
        bad_d  = (acc && !msg_status[7]) || (bad_q && !(socmidi_read && socmidi_addr == 3'd1));
        dout_d = !socmidi_read ? dout_q :
                 socmidi_addr == 3'd0 ? (not_empty ? mem[rd_q] : 8'h00) :
                 socmidi_addr == 3'd1 ? {cnt_q, bad_q, full, not_empty} : 8'h00;
        irq_d  = not_empty;
        rdy_d  = 1'b1;
    end

    // state registers with asynchronous active-low reset
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q <= IDLE;
            st_q    <= 8'h00;
            d1_q    <= 8'h00;
            d2_q    <= 8'h00;
            len_q   <= 2'd0;
            last_q  <= 8'h00;
            dout_q  <= 8'h00;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= 5'd0;
            bad_q   <= 1'b0;
            irq_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            len_q   <= len_d;
            last_q  <= last_d;
            dout_q  <= dout_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            irq_q   <= irq_d;
            rdy_q   <= rdy_d;
        end
    end

    // FIFO storage; contents are meaningless once pointers reset, so no reset here
    always_ff @(posedge reg_clk) begin
        if (push)
            mem[wr_q] <= push_byte;
    end
endmodule
